// File: rtl/fpm_juiz.sv
`default_nettype none
// ============================================================================
// Module   : fpm_juiz
// Brief    : Result checker that walks the fpm result RAM against a golden
//            ROM and reports per-entry mismatches with a ULP tolerance.
// Revision : 1.0 - initial release
// ============================================================================
module fpm_juiz #(
    parameter int ULP_TOL = 0,
    parameter int N_ENT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [1:0]  ram_addr,
    input  logic [31:0] ram_data,
    output logic [1:0]  exp_addr,
    input  logic [31:0] exp_data,
    output logic        busy,
    output logic        check_done,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [2:0]  err_cnt
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_ADDR    = 2'd1;
    localparam logic [1:0]  S_CMP     = 2'd2;
    localparam logic [1:0]  S_DONE    = 2'd3;
    localparam logic [2:0]  c_last    = 3'(N_ENT - 1);
    localparam logic [30:0] c_ulp_tol = 31'(ULP_TOL);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_start_q;
    logic [2:0]  r_idx;
    logic [3:0]  r_fail_mask;
    logic [2:0]  r_err_cnt;
    logic        w_launch;
    logic        w_enter_run;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_both_zero;
    logic [30:0] w_diff;
    logic        w_match;

    assign w_launch    = start & ~r_start_q;
    assign w_enter_run = w_launch && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Floating-point class decode; NaN payloads and zero signs are don't-cares.
    assign w_a_nan     = (&ram_data[30:23]) & (|ram_data[22:0]);
    assign w_b_nan     = (&exp_data[30:23]) & (|exp_data[22:0]);
    assign w_a_inf     = (&ram_data[30:23]) & ~(|ram_data[22:0]);
    assign w_b_inf     = (&exp_data[30:23]) & ~(|exp_data[22:0]);
    assign w_both_zero = ~(|ram_data[30:0]) & ~(|exp_data[30:0]);
    assign w_diff      = (ram_data[30:0] >= exp_data[30:0]) ? (ram_data[30:0] - exp_data[30:0])
                                                            : (exp_data[30:0] - ram_data[30:0]);

    always_comb begin
        w_match = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_match = w_a_nan && w_b_nan;
        end else if (w_a_inf || w_b_inf) begin
            w_match = (ram_data == exp_data);
        end else if (w_both_zero) begin
            w_match = 1'b1;
        end else if (ram_data[31] != exp_data[31]) begin
            w_match = 1'b0;
        end else begin
            w_match = (w_diff <= c_ulp_tol);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next_state = S_ADDR;
            S_ADDR:  w_next_state = S_CMP;
            S_CMP:   w_next_state = (r_idx < c_last) ? S_ADDR : S_DONE;
            S_DONE:  if (w_launch) w_next_state = S_ADDR;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_idx       <= 3'd0;
            r_fail_mask <= 4'd0;
            r_err_cnt   <= 3'd0;
        end else begin
            r_start_q <= start;
            if (w_enter_run) begin
                r_idx       <= 3'd0;
                r_fail_mask <= 4'd0;
                r_err_cnt   <= 3'd0;
            end else if (r_state == S_CMP) begin
                if (!w_match) begin
                    r_fail_mask[r_idx[1:0]] <= 1'b1;
                    r_err_cnt               <= r_err_cnt + 3'd1;
                end
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    always_comb begin
        busy       = (r_state == S_ADDR) || (r_state == S_CMP);
        check_done = (r_state == S_DONE);
        pass       = (r_state == S_DONE) && (r_err_cnt == 3'd0);
        ram_addr   = busy ? r_idx[1:0] : 2'd0;
    end

    assign exp_addr  = ram_addr;
    assign fail_mask = r_fail_mask;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpm_juiz.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpm_juiz
// Brief    : Directed self-checking bench for fpm_juiz (ULP_TOL 0 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpm_juiz;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] ram_mem  [4];
    logic [31:0] gold_mem [4];

    logic [1:0]  ram_addr0, exp_addr0, ram_addr1, exp_addr1;
    logic [31:0] ram_data0, exp_data0, ram_data1, exp_data1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [3:0]  mask0, mask1;
    logic [2:0]  cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign ram_data0 = ram_mem[ram_addr0];
    assign exp_data0 = gold_mem[exp_addr0];
    assign ram_data1 = ram_mem[ram_addr1];
    assign exp_data1 = gold_mem[exp_addr1];

    fpm_juiz #(.ULP_TOL(0), .N_ENT(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .ram_addr(ram_addr0), .ram_data(ram_data0),
        .exp_addr(exp_addr0), .exp_data(exp_data0),
        .busy(busy0), .check_done(done0), .pass(pass0),
        .fail_mask(mask0), .err_cnt(cnt0)
    );

    fpm_juiz #(.ULP_TOL(1), .N_ENT(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .ram_addr(ram_addr1), .ram_data(ram_data1),
        .exp_addr(exp_addr1), .exp_data(exp_data1),
        .busy(busy1), .check_done(done1), .pass(pass1),
        .fail_mask(mask1), .err_cnt(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_equal();
        for (int i = 0; i < 4; i++) begin
            ram_mem[i]  = 32'h3F80_0000 + 32'(i);
            gold_mem[i] = 32'h3F80_0000 + 32'(i);
        end
    endtask

    // Launch with a fresh start edge, optionally trace addresses, and check
    // that check_done rises exactly 8 edges after the launch edge.
    task automatic do_run(input string tag, input bit trace);
        start = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 0) start = 1'b0;
            if (trace) begin
                check($sformatf("%s_addr%0d", tag, j), 32'(ram_addr0), 32'(j / 2));
                check($sformatf("%s_eaddr%0d", tag, j), 32'(exp_addr0), 32'(j / 2));
                check($sformatf("%s_busy%0d", tag, j), 32'(busy0), 32'd1);
            end
        end
        check({tag, "_done_early"}, 32'(done0), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done0), 32'd1);
        check({tag, "_busy_end"}, 32'(busy0), 32'd0);
        check({tag, "_addr_end"}, 32'(ram_addr0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_equal();
        tick();
        tick();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_mask", 32'(mask0), 32'd0);
        check("rst_cnt",  32'(cnt0),  32'd0);
        check("rst_addr", 32'(ram_addr0), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy0), 32'd0);

        // All entries equal
        do_run("s1", 1'b1);
        check("s1_pass", 32'(pass0), 32'd1);
        check("s1_mask", 32'(mask0), 32'd0);
        check("s1_cnt",  32'(cnt0),  32'd0);

        // One ULP off on entry 2: fails at tol 0, passes at tol 1
        fill_equal();
        ram_mem[2]  = 32'h4040_0001;
        gold_mem[2] = 32'h4040_0000;
        do_run("s2", 1'b0);
        check("s2_pass0", 32'(pass0), 32'd0);
        check("s2_mask0", 32'(mask0), 32'b0100);
        check("s2_cnt0",  32'(cnt0),  32'd1);
        check("s2_pass1", 32'(pass1), 32'd1);
        check("s2_mask1", 32'(mask1), 32'd0);

        // Signed zero, NaN payload, inf vs max finite
        fill_equal();
        ram_mem[0] = 32'h8000_0000; gold_mem[0] = 32'h0000_0000;
        ram_mem[1] = 32'h7FC0_0001; gold_mem[1] = 32'h7FC0_0000;
        ram_mem[3] = 32'h7F80_0000; gold_mem[3] = 32'h7F7F_FFFF;
        do_run("s3", 1'b0);
        check("s3_mask1", 32'(mask1), 32'b1000);
        check("s3_cnt1",  32'(cnt1),  32'd1);
        check("s3_pass1", 32'(pass1), 32'd0);
        check("s3_mask0", 32'(mask0), 32'b1000);

        // Reset during CMP of entry 1, start held high across reset
        fill_equal();
        ram_mem[0] = 32'h3F80_0005;
        start = 1'b1;
        tick();
        tick();
        tick();
        check("s4_mask_pre", 32'(mask0), 32'b0001);
        tick();
        check("s4_in_cmp1", 32'(ram_addr0), 32'd1);
        rst = 1'b1;
        tick();
        check("s4_busy", 32'(busy0), 32'd0);
        check("s4_addr", 32'(ram_addr0), 32'd0);
        check("s4_mask", 32'(mask0), 32'd0);
        check("s4_cnt",  32'(cnt0),  32'd0);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) tick();
        check("s4_busy_run", 32'(busy0), 32'd1);
        tick();
        check("s4_done", 32'(done0), 32'd1);
        check("s4_mask_end", 32'(mask0), 32'b0001);
        check("s4_cnt_end",  32'(cnt0),  32'd1);
        tick();
        tick();
        check("s4_no_relaunch", 32'(busy0), 32'd0);
        check("s4_done_held",   32'(done0), 32'd1);
        start = 1'b0;
        tick();

        // Second start pulse mid-run is ignored; relaunch from DONE clears
        fill_equal();
        ram_mem[1] = 32'h3F80_0009;
        start = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            start = (j == 3);
            if (j == 8) check("s5_done_early", 32'(done0), 32'd0);
        end
        check("s5_done", 32'(done0), 32'd1);
        check("s5_mask", 32'(mask0), 32'b0010);
        check("s5_pass", 32'(pass0), 32'd0);
        fill_equal();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s5_re_busy", 32'(busy0), 32'd1);
        check("s5_re_done", 32'(done0), 32'd0);
        check("s5_re_mask", 32'(mask0), 32'd0);
        check("s5_re_cnt",  32'(cnt0),  32'd0);
        for (int j = 0; j < 7; j++) tick();
        check("s5_re_done_early", 32'(done0), 32'd0);
        tick();
        check("s5_re_done_end", 32'(done0), 32'd1);
        check("s5_re_pass", 32'(pass0), 32'd1);
        tick();

        // All entries differ in sign
        for (int i = 0; i < 4; i++) begin
            ram_mem[i]  = 32'h3F80_0000;
            gold_mem[i] = 32'hBF80_0000;
        end
        do_run("s6", 1'b0);
        check("s6_cnt",  32'(cnt0),  32'd4);
        check("s6_mask", 32'(mask0), 32'b1111);
        check("s6_pass", 32'(pass0), 32'd0);
        check("s6_cnt1", 32'(cnt1),  32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpm_juiz.md
FPM_JUIZ -- requirements
Module: fpm_juiz

Interface
REQ-001 SHALL have parameter ULP_TOL, default 0: maximum allowed unsigned distance, in ULPs, between a finite result and its expected value.
REQ-002 SHALL have parameter N_ENT, default 4: number of RAM result entries to check; the address width is fixed at 2 bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: the fpm `done` level; a 0->1 transition launches a check run.
REQ-006 SHALL have port ram_addr, output, 2: drives the fpm `ram_addr_juiz` input.
REQ-007 SHALL have port ram_data, input, 32: the fpm `ram_out_juiz`; combinational read of ram_addr.
REQ-008 SHALL have port exp_addr, output, 2: address into the golden-value ROM; always equal to ram_addr.
REQ-009 SHALL have port exp_data, input, 32: golden IEEE-754 single value; combinational read of exp_addr.
REQ-010 SHALL have port busy, output, 1: high while a run is in progress.
REQ-011 SHALL have port check_done, output, 1: high once a run completes; held until the next run or reset.
REQ-012 SHALL have port pass, output, 1: valid while check_done=1; 1 iff err_cnt==0.
REQ-013 SHALL have port fail_mask, output, 4: bit i set iff entry i mismatched.
REQ-014 SHALL have port err_cnt, output, 3: number of mismatching entries, range 0..4.

Function
REQ-015 SHALL register start into start_q every cycle, and detect launch as start & ~start_q.
REQ-016 SHALL implement FSM states IDLE, ADDR, CMP, DONE.
- IDLE -> ADDR on launch.
- ADDR -> CMP unconditionally.
- CMP -> ADDR if idx < N_ENT-1, else CMP -> DONE.
- DONE -> ADDR on launch; otherwise stays in DONE.
REQ-017 SHALL, on entering ADDR from IDLE or DONE, clear idx, fail_mask, err_cnt, check_done and pass.
REQ-018 SHALL drive ram_addr = exp_addr = idx in ADDR and CMP, and 0 in IDLE and DONE.
REQ-019 SHALL, in CMP, evaluate the match of ram_data against exp_data, and register the result on the edge leaving CMP.
- On mismatch: set fail_mask[idx] and increment err_cnt.
- On any exit from CMP: increment idx.
REQ-020 SHALL apply these match rules, in priority order:
- Either operand NaN (exponent 0xFF, mantissa != 0): match iff both are NaN; the payload is ignored.
- Either operand infinite: match iff the two words are bit-identical.
- Both operands zero (bits[30:0]==0): match regardless of sign.
- Signs differ: mismatch.
- Otherwise: match iff |a[30:0] - b[30:0]| <= ULP_TOL, computed as 31-bit unsigned with no wrap.
REQ-021 SHALL assert busy in ADDR and CMP only.
REQ-022 SHALL assert check_done and a valid pass in DONE only.
REQ-023 SHALL make the latency from the launch-sampling edge to check_done=1 exactly 2*N_ENT cycles (8 with the defaults).
REQ-024 SHALL ignore a launch edge while busy=1; start_q still tracks start.
REQ-025 SHALL NOT start a new run while start is held high; only a fresh 0->1 edge relaunches.
REQ-026 SHALL never let err_cnt exceed N_ENT.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, force the following, regardless of state (including mid-run):
- state=IDLE, idx=0, start_q=0.
- ram_addr=0, busy=0, check_done=0, pass=0, fail_mask=0, err_cnt=0.
REQ-028 SHALL treat start=1 at the first edge after rst deasserts as a launch, since start_q=0.

Verification
REQ-029 SHALL be verified with the following directed scenarios:
- All 4 RAM words equal golden, start 0->1 -> ram_addr steps 0,0,1,1,2,2,3,3; check_done=1 after 8 cycles; pass=1; fail_mask=0000; err_cnt=0.
- Entry 2 RAM=0x40400001, golden=0x40400000, ULP_TOL=0 -> pass=0, fail_mask=0100, err_cnt=1; rerun with ULP_TOL=1 -> pass=1.
- Entry 0: 0x80000000 vs 0x00000000. Entry 1: 0x7FC00001 vs 0x7FC00000. Entry 3: 0x7F800000 vs 0x7F7FFFFF, ULP_TOL=1. -> fail_mask=1000, err_cnt=1.
- rst=1 asserted during CMP of entry 1 -> next cycle busy=0, ram_addr=0, fail_mask=0; start held high after reset -> new run launches and completes normally.
- Second 0->1 start pulse at cycle 3 of a run -> ignored, check_done at cycle 8; after start drops and rises again in DONE -> outputs clear, new 8-cycle run.
- All 4 entries mismatching by sign (0x3F800000 vs 0xBF800000) -> err_cnt=4, fail_mask=1111, pass=0.
